// File: rtl/core_defines.sv
// Shared definitions for the core memory path: word width and the
// requester tag carried through the arbiter's in-order FIFO.
package core_defines;
    localparam int WORD_WIDTH = 32;

    typedef enum logic {SRC_INSTR, SRC_DATA} mem_src_e;
endpackage

// File: rtl/mem_arbiter_tag_fifo.sv
// In-order FIFO of requester tags: one entry per granted address phase,
// popped when the matching response returns.
module tag_fifo
    import core_defines::*;
#(
    parameter int  DEPTH  = 2,
    parameter type elem_t = mem_src_e
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  elem_t push_data,
    input  logic  pop,
    output elem_t head,
    output logic  full,
    output logic  empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    elem_t         slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~full;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one memory port with address-phase locking,
// fetch starvation guard and in-order response routing.
//
// state        | meaning
// UNLOCKED     | free to pick a source from the live requests
// LOCKED_INSTR | fetch address phase presented, waiting for mem_gnt_i
// LOCKED_DATA  | data address phase presented, waiting for mem_gnt_i
module mem_arbiter #(
    parameter int WORD_WIDTH      = core_defines::WORD_WIDTH,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic [WORD_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [WORD_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    input  logic [WORD_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [WORD_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [WORD_WIDTH-1:0] data_rdata_o,
    output logic                  mem_req_o,
    output logic [WORD_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i,
    output logic                  err_o
);
    import core_defines::mem_src_e;
    import core_defines::SRC_INSTR;
    import core_defines::SRC_DATA;

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {UNLOCKED, LOCKED_INSTR, LOCKED_DATA} lock_state_e;

    lock_state_e   lock_state;
    logic [SW-1:0] starve_cnt;
    logic          err_q;
    mem_src_e      sel;
    mem_src_e      head;
    logic          src_req;
    logic          granted;
    logic          sel_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          rsp_ok;

    always_comb begin
        sel     = SRC_INSTR;
        src_req = 1'b0;
        case (lock_state)
            LOCKED_INSTR: begin
                sel     = SRC_INSTR;
                src_req = instr_req_i;
            end
            LOCKED_DATA: begin
                sel     = SRC_DATA;
                src_req = data_req_i;
            end
            default: begin
                if (instr_req_i && starve_cnt == SW'(STARVE_LIMIT)) sel = SRC_INSTR;
                else if (data_req_i)                                  sel = SRC_DATA;
                else                                                  sel = SRC_INSTR;
                src_req = instr_req_i | data_req_i;
            end
        endcase
    end

    // A full tag FIFO gates the request but leaves the lock untouched.
    assign sel_data    = (sel == SRC_DATA);
    assign mem_req_o   = rst_n & src_req & ~fifo_full;
    assign mem_addr_o  = !mem_req_o ? '0 : (sel_data ? data_addr_i : instr_addr_i);
    assign mem_we_o    = mem_req_o & sel_data & data_we_i;
    assign mem_be_o    = !mem_req_o ? 4'h0 : (sel_data ? data_be_i : 4'hF);
    assign mem_wdata_o = (mem_req_o & sel_data) ? data_wdata_i : '0;

    assign granted     = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = granted & ~sel_data;
    assign data_gnt_o  = granted & sel_data;

    assign rsp_ok         = rst_n & mem_rvalid_i & ~fifo_empty;
    assign instr_rvalid_o = rsp_ok & (head == SRC_INSTR);
    assign data_rvalid_o  = rsp_ok & (head == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign err_o          = err_q;

    tag_fifo #(
        .DEPTH  (MAX_OUTSTANDING),
        .elem_t (mem_src_e)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (granted),
        .push_data (sel),
        .pop       (mem_rvalid_i),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_state <= UNLOCKED;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            if (granted)        lock_state <= UNLOCKED;
            else if (mem_req_o) lock_state <= sel_data ? LOCKED_DATA : LOCKED_INSTR;

            if (instr_gnt_o || !instr_req_i)
                starve_cnt <= '0;
            else if (data_gnt_o && starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);

            if (mem_rvalid_i && fifo_empty) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized plus directed bench for mem_arbiter against a queue-based
// behavioural model of arbitration, starvation and response routing.
module tb_mem_arbiter;
    localparam int W    = 32;
    localparam int MAXO = 2;
    localparam int LIM  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           instr_req_i;
    logic [W-1:0]   instr_addr_i;
    logic           instr_gnt_o;
    logic           instr_rvalid_o;
    logic [W-1:0]   instr_rdata_o;
    logic           data_req_i;
    logic [W-1:0]   data_addr_i;
    logic           data_we_i;
    logic [3:0]     data_be_i;
    logic [W-1:0]   data_wdata_i;
    logic           data_gnt_o;
    logic           data_rvalid_o;
    logic [W-1:0]   data_rdata_o;
    logic           mem_req_o;
    logic [W-1:0]   mem_addr_o;
    logic           mem_we_o;
    logic [3:0]     mem_be_o;
    logic [W-1:0]   mem_wdata_o;
    logic           mem_gnt_i;
    logic           mem_rvalid_i;
    logic [W-1:0]   mem_rdata_i;
    logic           err_o;

    mem_arbiter #(
        .WORD_WIDTH      (W),
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (LIM)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    // Model state: 0 = fetch, 1 = data; lock_src -1 means no lock held.
    int q[$];
    int lock_src;
    int starve;
    bit err_m;
    bit last_gi;
    bit last_gd;

    int n_pass;
    int n_total;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Compare all outputs against the model, then advance one clock.
    task automatic cyc();
        int         src;
        bit         rq;
        bit         ereq;
        bit         egi;
        bit         egd;
        bit         ehit;
        bit         rv;
        bit         gn;
        bit         ir;
        logic [W-1:0] eaddr;
        logic [W-1:0] ewd;
        logic [3:0] ebe;
        bit         ewe;

        if (lock_src >= 0) begin
            src = lock_src;
            rq  = (src == 1) ? data_req_i : instr_req_i;
        end else begin
            rq = instr_req_i | data_req_i;
            if (instr_req_i && starve == LIM) src = 0;
            else                              src = data_req_i ? 1 : 0;
        end
        ereq  = rst_n && rq && (q.size() < MAXO);
        eaddr = '0; ewd = '0; ebe = 4'h0; ewe = 1'b0;
        if (ereq && src == 1) begin
            eaddr = data_addr_i; ewd = data_wdata_i; ebe = data_be_i; ewe = data_we_i;
        end else if (ereq) begin
            eaddr = instr_addr_i; ebe = 4'hF;
        end
        egi  = ereq && mem_gnt_i && src == 0;
        egd  = ereq && mem_gnt_i && src == 1;
        ehit = rst_n && mem_rvalid_i && q.size() > 0;

        check("mem_req", mem_req_o, ereq);
        check("mem_addr", mem_addr_o, eaddr);
        check("mem_we", mem_we_o, ewe);
        check("mem_be", mem_be_o, ebe);
        check("mem_wdata", mem_wdata_o, ewd);
        check("instr_gnt", instr_gnt_o, egi);
        check("data_gnt", data_gnt_o, egd);
        check("instr_rvalid", instr_rvalid_o, ehit && q[0] == 0);
        check("data_rvalid", data_rvalid_o, ehit && q[0] == 1);
        check("instr_rdata", instr_rdata_o, mem_rdata_i);
        check("data_rdata", data_rdata_o, mem_rdata_i);
        check("err", err_o, err_m);
        last_gi = egi;
        last_gd = egd;
        rv = mem_rvalid_i;
        gn = mem_gnt_i;
        ir = instr_req_i;

        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            lock_src = -1;
            starve   = 0;
            err_m    = 1'b0;
        end else begin
            if (rv) begin
                if (q.size() == 0) err_m = 1'b1;
                else               void'(q.pop_front());
            end
            if (ereq && gn) q.push_back(src);
            if (ereq && gn) lock_src = -1;
            else if (ereq)  lock_src = src;
            if (egi || !ir)  starve = 0;
            else if (egd)    starve = (starve < LIM) ? starve + 1 : LIM;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom();
            #1;
            cyc();
        end
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        int first_fetch;
        n_pass = 0; n_total = 0;
        q.delete(); lock_src = -1; starve = 0; err_m = 1'b0;
        rst_n = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'h0;
        data_req_i = 1'b1; data_addr_i = 32'h0; data_we_i = 1'b0;
        data_be_i = 4'hF; data_wdata_i = 32'h0;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_instr_gnt", instr_gnt_o, 1'b0);
        check("rst_data_gnt", data_gnt_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        @(negedge clk);

        // Idle after reset.
        rst_n = 1'b1; instr_req_i = 1'b0; data_req_i = 1'b0; #1;
        check("idle_mem_req", mem_req_o, 1'b0);
        cyc();

        // Fetch-only stream with single-cycle responses.
        instr_req_i = 1'b1; instr_addr_i = 32'h0; mem_gnt_i = 1'b1; #1;
        check("f0_gnt", instr_gnt_o, 1'b1);
        check("f0_addr", mem_addr_o, 32'h0);
        cyc();
        instr_addr_i = 32'h4; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA0; #1;
        check("f1_gnt", instr_gnt_o, 1'b1);
        check("f1_addr", mem_addr_o, 32'h4);
        check("f0_rvalid", instr_rvalid_o, 1'b1);
        check("f0_rdata", instr_rdata_o, 32'hA0);
        cyc();
        instr_addr_i = 32'h8; mem_rdata_i = 32'hA4; #1;
        check("f2_addr", mem_addr_o, 32'h8);
        check("f1_rvalid", instr_rvalid_o, 1'b1);
        cyc();
        instr_req_i = 1'b0; mem_rdata_i = 32'hA8; #1;
        check("f2_rvalid", instr_rvalid_o, 1'b1);
        check("f2_data_rvalid", data_rvalid_o, 1'b0);
        check("f_idle_req", mem_req_o, 1'b0);
        cyc();
        mem_rvalid_i = 1'b0;

        // Data priority and fetch starvation limit.
        first_fetch = -1;
        instr_req_i = 1'b1; instr_addr_i = 32'h20;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF;
        for (int k = 0; k < 6; k++) begin
            data_addr_i  = 32'h200 + 32'(4 * k);
            mem_rvalid_i = (q.size() > 0);
            #1;
            if (k == 0) check("prio_data_first", data_gnt_o, 1'b1);
            if (instr_gnt_o && first_fetch < 0) first_fetch = k;
            cyc();
        end
        check("starve_fifth_to_fetch", first_fetch, 4);
        drain();

        // Lock holds the fetch address while grant is withheld.
        instr_req_i = 1'b1; instr_addr_i = 32'h40; mem_gnt_i = 1'b0; #1;
        check("lock_addr0", mem_addr_o, 32'h40);
        cyc();
        data_req_i = 1'b1; data_addr_i = 32'h300; #1;
        check("lock_addr1", mem_addr_o, 32'h40);
        cyc();
        #1;
        check("lock_addr2", mem_addr_o, 32'h40);
        check("lock_no_gnt", instr_gnt_o, 1'b0);
        cyc();
        mem_gnt_i = 1'b1; #1;
        check("lock_fetch_gnt", instr_gnt_o, 1'b1);
        check("lock_data_wait", data_gnt_o, 1'b0);
        cyc();
        instr_req_i = 1'b0; #1;
        check("lock_data_next", data_gnt_o, 1'b1);
        cyc();
        drain();

        // Outstanding limit: full FIFO blocks, same-cycle pop does not lift it.
        instr_req_i = 1'b1; instr_addr_i = 32'h80; #1;
        cyc();
        instr_addr_i = 32'h84; #1;
        cyc();
        instr_addr_i = 32'h88; #1;
        check("full_req_low", mem_req_o, 1'b0);
        cyc();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234; #1;
        check("full_pop_req_low", mem_req_o, 1'b0);
        check("full_pop_rvalid", instr_rvalid_o, 1'b1);
        cyc();
        mem_rvalid_i = 1'b0; #1;
        check("full_resume_gnt", instr_gnt_o, 1'b1);
        cyc();
        drain();

        // Interleaved store then fetch; responses routed in order.
        data_req_i = 1'b1; data_addr_i = 32'h100; data_we_i = 1'b1;
        data_be_i = 4'h3; data_wdata_i = 32'hDEADBEEF;
        instr_req_i = 1'b1; instr_addr_i = 32'h10; #1;
        check("st_gnt", data_gnt_o, 1'b1);
        check("st_addr", mem_addr_o, 32'h100);
        check("st_we", mem_we_o, 1'b1);
        check("st_be", mem_be_o, 4'h3);
        check("st_wdata", mem_wdata_o, 32'hDEADBEEF);
        cyc();
        data_req_i = 1'b0; #1;
        check("il_fetch_gnt", instr_gnt_o, 1'b1);
        check("il_fetch_be", mem_be_o, 4'hF);
        check("il_fetch_we", mem_we_o, 1'b0);
        cyc();
        instr_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55; #1;
        check("il_rsp1_data", data_rvalid_o, 1'b1);
        check("il_rsp1_instr", instr_rvalid_o, 1'b0);
        cyc();
        mem_rdata_i = 32'h66; #1;
        check("il_rsp2_instr", instr_rvalid_o, 1'b1);
        check("il_rsp2_data", data_rvalid_o, 1'b0);
        cyc();
        mem_rvalid_i = 1'b0;

        // Randomized traffic with a mid-stream reset.
        last_gi = 1'b1; last_gd = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst_n = !(i == 1500 || i == 1501);
            if (!instr_req_i || last_gi) begin
                instr_req_i  = ($urandom_range(0, 3) != 0);
                instr_addr_i = $urandom() & 32'hFFFF_FFFC;
            end
            if (!data_req_i || last_gd) begin
                data_req_i   = ($urandom_range(0, 3) != 0);
                data_addr_i  = $urandom();
                data_we_i    = $urandom_range(0, 1);
                data_be_i    = 4'($urandom_range(0, 15));
                data_wdata_i = $urandom();
            end
            mem_gnt_i    = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i  = $urandom();
            #1;
            cyc();
        end
        rst_n = 1'b1;
        mem_gnt_i = 1'b1;
        drain();

        // Response with nothing outstanding sets the sticky error.
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77; #1;
        check("orphan_no_irv", instr_rvalid_o, 1'b0);
        check("orphan_no_drv", data_rvalid_o, 1'b0);
        cyc();
        mem_rvalid_i = 1'b0; #1;
        check("err_set", err_o, 1'b1);
        cyc();
        repeat (3) begin
            #1;
            cyc();
        end
        #1;
        check("err_sticky", err_o, 1'b1);
        rst_n = 1'b0; #1;
        cyc();
        rst_n = 1'b1; #1;
        check("err_cleared", err_o, 1'b0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one unified memory port between the core's instruction-fetch and data (load/store) requesters. Both sides use the core's req/gnt/rvalid protocol. The arbiter picks one requester per address phase and locks that choice until the grant. It records the source of each granted transaction in an in-order tag FIFO so each rvalid/rdata goes back to the right side. It sits between the core's `instr_*`/`data_*` ports and a single-ported SRAM or bus bridge.

## Interface
- `WORD_WIDTH`, 32, address/data width
- `MAX_OUTSTANDING`, 2, granted-but-unanswered transactions allowed (power of 2, ≥1)
- `STARVE_LIMIT`, 4, consecutive data grants with fetch pending before fetch is forced to win
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `instr_req_i`  in  1  fetch request, held until `instr_gnt_o`
- `instr_addr_i`  in  WORD_WIDTH  fetch address
- `instr_gnt_o`  out  1  fetch address phase accepted
- `instr_rvalid_o`  out  1  fetch response valid
- `instr_rdata_o`  out  WORD_WIDTH  fetch response data
- `data_req_i`  in  1  load/store request, held until `data_gnt_o`
- `data_addr_i`  in  WORD_WIDTH  data address
- `data_we_i`  in  1  1 = store
- `data_be_i`  in  4  byte enables
- `data_wdata_i`  in  WORD_WIDTH  store data
- `data_gnt_o`  out  1  data address phase accepted
- `data_rvalid_o`  out  1  data response valid (loads and stores)
- `data_rdata_o`  out  WORD_WIDTH  load data
- `mem_req_o`  out  1  unified request
- `mem_addr_o`  out  WORD_WIDTH  address
- `mem_we_o`  out  1  write enable
- `mem_be_o`  out  4  byte enables
- `mem_wdata_o`  out  WORD_WIDTH  write data
- `mem_gnt_i`  in  1  memory accepted address phase
- `mem_rvalid_i`  in  1  response valid, in request order
- `mem_rdata_i`  in  WORD_WIDTH  response data
- `err_o`  out  1  sticky: rvalid arrived with no outstanding transaction

## Operation
- Lock state: `UNLOCKED` / `LOCKED(src)`. In `UNLOCKED`, pick a source combinationally from the current requests. If `mem_req_o` is driven without `mem_gnt_i`, move to `LOCKED(src)`. The next cycle must present the same source. Return to `UNLOCKED` on the grant cycle.
- Priority in `UNLOCKED`: data wins over fetch. Exception: when `starve_cnt == STARVE_LIMIT` and `instr_req_i` is high, fetch wins.
- `starve_cnt`:
  - +1 on each data grant while `instr_req_i` is high.
  - Cleared on a fetch grant, or when `instr_req_i` is low.
  - Saturates at `STARVE_LIMIT`.
- Mux:
  - Fetch selected: `mem_we_o=0`, `mem_be_o=4'hF`, `mem_wdata_o=0`.
  - Data selected: the data-side signals pass through.
- Grants: `instr_gnt_o = mem_gnt_i & mem_req_o & sel==INSTR`, and the matching rule for data. Never both in one cycle.
- `mem_req_o` is low when the tag FIFO is full. A pop in the same cycle does not lift this. The FIFO-full condition also overrides a lock: `mem_req_o` drops, and the lock is kept.
- Tag FIFO:
  - Push the source on every `mem_gnt_i & mem_req_o`.
  - Pop on `mem_rvalid_i`.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- Responses:
  - `instr_rvalid_o = mem_rvalid_i & head==INSTR`, and the matching rule for data.
  - `mem_rdata_i` is broadcast to both `*_rdata_o`.
- `mem_rvalid_i` with the FIFO empty: set `err_o`, no pop, no `*_rvalid_o`. `err_o` clears only on reset.

## Timing
- Zero-cycle request path: request to `mem_req_o`, and `mem_gnt_i` to `*_gnt_o`, are combinational.
- Zero-cycle response path: `mem_rvalid_i` to `*_rvalid_o` is combinational.
- Reset (synchronous, `rst_n` low at a rising edge):
  - Lock → `UNLOCKED`.
  - FIFO empty.
  - `starve_cnt=0`.
  - `err_o=0`.
- While `rst_n` is low, all grant/valid/req outputs are 0. `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o` are 0 whenever `mem_req_o` is 0.
- Reset in the middle of a transaction drops in-flight tags. Responses that arrive after reset set `err_o`; this is by design, and the system must reset the memory together with the arbiter.
- Back-to-back grants every cycle are supported until `MAX_OUTSTANDING` transactions are in flight.

## Structure
- `core_defines` package:
  - `WORD_WIDTH`
  - `typedef enum logic {SRC_INSTR, SRC_DATA} mem_src_e`
- Sub-module `tag_fifo`:
  - Parameters: depth, element type `mem_src_e`.
  - Ports: push, pop, head, full, empty.
  - Pointers wrap modulo depth.
  - Empty-pop is ignored.
- Top level: lock register, starvation counter, muxes, error flag.

## Test plan
- Fetch only, `mem_gnt_i=1`, rvalid 1 cycle later, addresses 0x0, 0x4, 0x8 -> `instr_gnt_o` is high in the same cycle as the request; three `instr_rvalid_o` pulses, in order.
- Fetch and data requested together -> data granted first, fetch granted next. With `STARVE_LIMIT=4` and data requesting continuously, the 5th grant goes to fetch.
- `mem_gnt_i` held low for 3 cycles while fetch is pending and data rises in cycle 2 -> `mem_addr_o` stays at the fetch address for all 3 cycles; fetch gets the grant.
- `MAX_OUTSTANDING=2`, two grants, no rvalid -> `mem_req_o` stays 0 until the first rvalid; the next request is then granted the following cycle.
- Interleaved grants data@0x100 (store, be=4'h3), fetch@0x10 -> the 1st rvalid goes to `data_rvalid_o` and the 2nd to `instr_rvalid_o`. Store fields appear on mem unchanged.
- `mem_rvalid_i=1` with the FIFO empty -> `err_o=1` next cycle, staying high until `rst_n=0`; no `*_rvalid_o`.
